// File: rtl/zap_memory_align.sv
// -----------------------------------------------------------------------------
// zap_memory_align
//
// Memory-completion stage. Accepts the registered instruction from the
// post-ALU stage, tracks the outstanding data-bus transaction until it is
// acknowledged, aligns and sign/zero-extends read data, flags data aborts and
// hands one registered result per instruction to writeback. It is the only
// source of the data-side stall back to the upstream stages.
//
// Ports
//   i_clk, i_reset_n             clock, asynchronous active-low reset
//   i_clear_from_writeback       synchronous flush (highest priority after reset)
//   i_dav_ff .. i_data_wb_we_ff  instruction valid, load, bus request qualifiers
//   i_alu_result_ff, i_mem_address_ff, i_pc_plus_8_ff, i_flags_ff
//   i_destination_index_ff, i_mem_srcdest_index_ff
//   i_mem_*_enable_ff            load size / sign selects (word if none)
//   i_abt_ff .. i_und_ff         upstream exception flags
//   i_mem_ack, i_mem_fault, i_mem_rd_data   data bus response
//   o_stall                      combinational stall to all upstream stages
//   o_dav_ff .. o_und_ff         registered result to writeback
//   o_data_abt_ff, o_fault_address_ff       data abort and its address
// -----------------------------------------------------------------------------
module zap_memory_align #(
  parameter  int PHY_REGS = 46,
  parameter  int FLAG_WDT = 32,
  localparam int IW       = $clog2(PHY_REGS)
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_clear_from_writeback,
  input  logic                i_dav_ff,
  input  logic                i_mem_load_ff,
  input  logic                i_data_wb_cyc_ff,
  input  logic                i_data_wb_stb_ff,
  input  logic                i_data_wb_we_ff,
  input  logic [31:0]         i_alu_result_ff,
  input  logic [31:0]         i_mem_address_ff,
  input  logic [31:0]         i_pc_plus_8_ff,
  input  logic [FLAG_WDT-1:0] i_flags_ff,
  input  logic [IW-1:0]       i_destination_index_ff,
  input  logic [IW-1:0]       i_mem_srcdest_index_ff,
  input  logic                i_mem_unsigned_byte_enable_ff,
  input  logic                i_mem_signed_byte_enable_ff,
  input  logic                i_mem_unsigned_halfword_enable_ff,
  input  logic                i_mem_signed_halfword_enable_ff,
  input  logic                i_abt_ff,
  input  logic                i_irq_ff,
  input  logic                i_fiq_ff,
  input  logic                i_swi_ff,
  input  logic                i_und_ff,
  input  logic                i_mem_ack,
  input  logic                i_mem_fault,
  input  logic [31:0]         i_mem_rd_data,
  output logic                o_stall,
  output logic                o_dav_ff,
  output logic [31:0]         o_alu_result_ff,
  output logic [31:0]         o_pc_plus_8_ff,
  output logic [FLAG_WDT-1:0] o_flags_ff,
  output logic [IW-1:0]       o_destination_index_ff,
  output logic [IW-1:0]       o_mem_srcdest_index_ff,
  output logic                o_mem_load_ff,
  output logic [31:0]         o_mem_rd_data_ff,
  output logic                o_abt_ff,
  output logic                o_irq_ff,
  output logic                o_fiq_ff,
  output logic                o_swi_ff,
  output logic                o_und_ff,
  output logic                o_data_abt_ff,
  output logic [31:0]         o_fault_address_ff
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SLEEP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic        memop_p0;
  logic        complete_p0;
  logic        pass_p0;
  logic [31:0] aligned_p0;

  // Word loads rotate; byte/halfword loads pick a lane and extend it.
  // A halfword at an odd address uses the same lane as the even address.
  function automatic logic [31:0] align_rd_data(
    input logic [31:0] data,
    input logic [1:0]  addr_lo,
    input logic        byte_u,
    input logic        byte_s,
    input logic        half_u,
    input logic        half_s
  );
    logic [63:0]        data_dbl;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic [31:0]        res;
    data_dbl = {data, data};
    lane_b   = data[{addr_lo, 3'b000} +: 8];
    lane_h   = data[{addr_lo[1], 4'b0000} +: 16];
    if (byte_u | byte_s) begin
      res = byte_s ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
    end else if (half_u | half_s) begin
      res = half_s ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
    end else begin
      res = data_dbl[{1'b0, addr_lo, 3'b000} +: 32];
    end
    return res;
  endfunction

  // ---- stage p0: request decode, next state, stall ----
  always_comb begin
    memop_p0    = i_dav_ff & i_data_wb_cyc_ff & i_data_wb_stb_ff;
    pass_p0     = (state == IDLE) & ~memop_p0;
    complete_p0 = (((state == IDLE) & memop_p0) | (state == WAIT)) & i_mem_ack;
    aligned_p0  = align_rd_data(i_mem_rd_data, i_mem_address_ff[1:0],
                                i_mem_unsigned_byte_enable_ff,
                                i_mem_signed_byte_enable_ff,
                                i_mem_unsigned_halfword_enable_ff,
                                i_mem_signed_halfword_enable_ff);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (memop_p0) begin
          if (!i_mem_ack)       state_nxt = WAIT;
          else if (i_mem_fault) state_nxt = SLEEP;
        end
      end
      WAIT: begin
        if (i_mem_ack) state_nxt = i_mem_fault ? SLEEP : IDLE;
      end
      SLEEP:   state_nxt = SLEEP;
      default: state_nxt = IDLE;
    endcase
    if (i_clear_from_writeback) state_nxt = IDLE;
  end

  // Gated by reset so the stall drops the instant reset asserts, even while
  // upstream still presents a memory request.
  always_comb begin
    o_stall = i_reset_n & ~i_clear_from_writeback & ~i_mem_ack &
              (((state == IDLE) & memop_p0) | (state == WAIT));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // ---- stage p1: registered result to writeback ----
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_dav_ff               <= 1'b0;
      o_alu_result_ff        <= '0;
      o_pc_plus_8_ff         <= '0;
      o_flags_ff             <= '0;
      o_destination_index_ff <= '0;
      o_mem_srcdest_index_ff <= '0;
      o_mem_load_ff          <= 1'b0;
      o_mem_rd_data_ff       <= '0;
      o_abt_ff               <= 1'b0;
      o_irq_ff               <= 1'b0;
      o_fiq_ff               <= 1'b0;
      o_swi_ff               <= 1'b0;
      o_und_ff               <= 1'b0;
      o_data_abt_ff          <= 1'b0;
      o_fault_address_ff     <= '0;
    end else if (i_clear_from_writeback) begin
      o_dav_ff      <= 1'b0;
      o_mem_load_ff <= 1'b0;
      o_data_abt_ff <= 1'b0;
      o_abt_ff      <= 1'b0;
      o_irq_ff      <= 1'b0;
      o_fiq_ff      <= 1'b0;
      o_swi_ff      <= 1'b0;
      o_und_ff      <= 1'b0;
    end else begin
      if (pass_p0 | complete_p0) begin
        o_alu_result_ff        <= i_alu_result_ff;
        o_pc_plus_8_ff         <= i_pc_plus_8_ff;
        o_flags_ff             <= i_flags_ff;
        o_destination_index_ff <= i_destination_index_ff;
        o_mem_srcdest_index_ff <= i_mem_srcdest_index_ff;
        o_abt_ff               <= i_abt_ff;
        o_irq_ff               <= i_irq_ff;
        o_fiq_ff               <= i_fiq_ff;
        o_swi_ff               <= i_swi_ff;
        o_und_ff               <= i_und_ff;
      end
      if (pass_p0) begin
        o_dav_ff      <= i_dav_ff;
        o_mem_load_ff <= 1'b0;
      end else if (complete_p0) begin
        o_dav_ff <= 1'b1;
        if (i_mem_fault) begin
          o_data_abt_ff      <= 1'b1;
          o_mem_load_ff      <= 1'b0;
          o_fault_address_ff <= i_mem_address_ff;
        end else begin
          // Stores complete the same way but never write a register.
          o_mem_load_ff    <= i_mem_load_ff & ~i_data_wb_we_ff;
          o_mem_rd_data_ff <= aligned_p0;
        end
      end else begin
        // Waiting on the bus or sleeping after an abort.
        o_dav_ff <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zap_memory_align.sv
module tb_zap_memory_align;

  localparam int IW = 6;

  typedef struct packed {
    logic        dav;
    logic        load;
    logic        abt;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] fa;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset_n, i_clear_from_writeback;
  logic        i_dav_ff, i_mem_load_ff, i_data_wb_cyc_ff, i_data_wb_stb_ff, i_data_wb_we_ff;
  logic [31:0] i_alu_result_ff, i_mem_address_ff, i_pc_plus_8_ff, i_flags_ff;
  logic [IW-1:0] i_destination_index_ff, i_mem_srcdest_index_ff;
  logic        i_ub, i_sb, i_uh, i_sh;
  logic        i_abt_ff, i_irq_ff, i_fiq_ff, i_swi_ff, i_und_ff;
  logic        i_mem_ack, i_mem_fault;
  logic [31:0] i_mem_rd_data;

  logic        o_stall, o_dav_ff, o_mem_load_ff, o_data_abt_ff;
  logic [31:0] o_alu_result_ff, o_pc_plus_8_ff, o_flags_ff, o_mem_rd_data_ff, o_fault_address_ff;
  logic [IW-1:0] o_destination_index_ff, o_mem_srcdest_index_ff;
  logic        o_abt_ff, o_irq_ff, o_fiq_ff, o_swi_ff, o_und_ff;

  zap_memory_align #(.PHY_REGS(46), .FLAG_WDT(32)) dut (
    .i_clk                             (clk),
    .i_reset_n                         (i_reset_n),
    .i_clear_from_writeback            (i_clear_from_writeback),
    .i_dav_ff                          (i_dav_ff),
    .i_mem_load_ff                     (i_mem_load_ff),
    .i_data_wb_cyc_ff                  (i_data_wb_cyc_ff),
    .i_data_wb_stb_ff                  (i_data_wb_stb_ff),
    .i_data_wb_we_ff                   (i_data_wb_we_ff),
    .i_alu_result_ff                   (i_alu_result_ff),
    .i_mem_address_ff                  (i_mem_address_ff),
    .i_pc_plus_8_ff                    (i_pc_plus_8_ff),
    .i_flags_ff                        (i_flags_ff),
    .i_destination_index_ff            (i_destination_index_ff),
    .i_mem_srcdest_index_ff            (i_mem_srcdest_index_ff),
    .i_mem_unsigned_byte_enable_ff     (i_ub),
    .i_mem_signed_byte_enable_ff       (i_sb),
    .i_mem_unsigned_halfword_enable_ff (i_uh),
    .i_mem_signed_halfword_enable_ff   (i_sh),
    .i_abt_ff                          (i_abt_ff),
    .i_irq_ff                          (i_irq_ff),
    .i_fiq_ff                          (i_fiq_ff),
    .i_swi_ff                          (i_swi_ff),
    .i_und_ff                          (i_und_ff),
    .i_mem_ack                         (i_mem_ack),
    .i_mem_fault                       (i_mem_fault),
    .i_mem_rd_data                     (i_mem_rd_data),
    .o_stall                           (o_stall),
    .o_dav_ff                          (o_dav_ff),
    .o_alu_result_ff                   (o_alu_result_ff),
    .o_pc_plus_8_ff                    (o_pc_plus_8_ff),
    .o_flags_ff                        (o_flags_ff),
    .o_destination_index_ff            (o_destination_index_ff),
    .o_mem_srcdest_index_ff            (o_mem_srcdest_index_ff),
    .o_mem_load_ff                     (o_mem_load_ff),
    .o_mem_rd_data_ff                  (o_mem_rd_data_ff),
    .o_abt_ff                          (o_abt_ff),
    .o_irq_ff                          (o_irq_ff),
    .o_fiq_ff                          (o_fiq_ff),
    .o_swi_ff                          (o_swi_ff),
    .o_und_ff                          (o_und_ff),
    .o_data_abt_ff                     (o_data_abt_ff),
    .o_fault_address_ff                (o_fault_address_ff)
  );

  res_t obs;
  always_comb obs = {o_dav_ff, o_mem_load_ff, o_data_abt_ff, o_mem_rd_data_ff,
                     o_alu_result_ff, o_fault_address_ff};

  res_t        scb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_rd = 32'h0;
  logic [31:0] m_fa = 32'h0;

  // Reference alignment written as shifts and masks.
  function automatic logic [31:0] ref_align(input logic [31:0] d, input logic [1:0] a,
                                            input logic [3:0] sz);
    logic [31:0] r;
    if (sz[3] | sz[2]) begin
      r = (d >> (8 * a)) & 32'hFF;
      if (sz[2] && r[7]) r = r | 32'hFFFF_FF00;
    end else if (sz[1] | sz[0]) begin
      r = (d >> (a[1] ? 16 : 0)) & 32'hFFFF;
      if (sz[0] && r[15]) r = r | 32'hFFFF_0000;
    end else begin
      r = (d >> (8 * a)) | (d << (32 - 8 * a));
    end
    return r;
  endfunction

  task automatic idle_inputs();
    i_clear_from_writeback = 0;
    i_dav_ff = 0; i_mem_load_ff = 0; i_data_wb_cyc_ff = 0; i_data_wb_stb_ff = 0;
    i_data_wb_we_ff = 0;
    i_alu_result_ff = 0; i_mem_address_ff = 0; i_pc_plus_8_ff = 0; i_flags_ff = 0;
    i_destination_index_ff = 0; i_mem_srcdest_index_ff = 0;
    {i_ub, i_sb, i_uh, i_sh} = 4'b0000;
    {i_abt_ff, i_irq_ff, i_fiq_ff, i_swi_ff, i_und_ff} = 5'b0;
    i_mem_ack = 0; i_mem_fault = 0; i_mem_rd_data = 0;
  endtask

  // Called just after a rising edge. Drives one memory op, acks it after
  // 'late' cycles, pushes the expected result (non-fault only) and returns
  // with inputs idle, just after the completing edge.
  // sz = {unsigned byte, signed byte, unsigned half, signed half}.
  task automatic drive_memop(input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] alu, input logic [3:0] sz,
                             input logic we, input logic ld, input int late,
                             input logic fault, output int stalls);
    res_t e;
    i_dav_ff = 1; i_data_wb_cyc_ff = 1; i_data_wb_stb_ff = 1;
    i_data_wb_we_ff = we; i_mem_load_ff = ld;
    {i_ub, i_sb, i_uh, i_sh} = sz;
    i_mem_address_ff = addr; i_alu_result_ff = alu;
    i_mem_ack = 0; i_mem_fault = 0; i_mem_rd_data = 32'h0;
    stalls = 0;
    for (int i = 0; i < late; i++) begin
      #1;
      if (o_stall) stalls++;
      @(posedge clk); #1;
    end
    i_mem_ack = 1; i_mem_fault = fault; i_mem_rd_data = data;
    #1;
    if (o_stall) stalls++;
    if (fault) begin
      m_fa = addr;
    end else begin
      m_rd = ref_align(data, addr[1:0], sz);
      e = {1'b1, ld & ~we, 1'b0, m_rd, alu, m_fa};
      scb.push_back(e);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    i_reset_n = 0;
    i_data_wb_cyc_ff = 1; i_data_wb_stb_ff = 1; i_alu_result_ff = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (o_stall !== 1'b0) begin
      fails++; $display("FAIL reset_stall_in_reset: got %b expected 0", o_stall);
    end
    i_reset_n = 1;
    #1;
    tests++;
    if (obs !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    tests++;
    if ({o_pc_plus_8_ff, o_flags_ff, o_destination_index_ff, o_mem_srcdest_index_ff,
         o_abt_ff, o_irq_ff, o_fiq_ff, o_swi_ff, o_und_ff, o_stall} !== '0) begin
      fails++; $display("FAIL reset_other_outputs: pc %h flags %h stall %b expected all 0",
                        o_pc_plus_8_ff, o_flags_ff, o_stall);
    end
    m_rd = 0; m_fa = 0;
    idle_inputs();
  endtask

  task automatic test_alu_passthrough();
    res_t e;
    @(posedge clk); #1;
    i_dav_ff = 1; i_alu_result_ff = 32'h12345678; i_pc_plus_8_ff = 32'h108;
    i_flags_ff = 32'hA000_0010; i_destination_index_ff = 6'd5; i_mem_srcdest_index_ff = 6'd9;
    i_irq_ff = 1; i_swi_ff = 1;
    e = {1'b1, 1'b0, 1'b0, m_rd, 32'h12345678, m_fa};
    scb.push_back(e);
    #1;
    tests++;
    if (o_stall !== 1'b0) begin
      fails++; $display("FAIL alu_stall: got %b expected 0", o_stall);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    tests++;
    e = scb.pop_front();
    if (obs !== e) begin
      fails++; $display("FAIL alu_result: got %h expected %h", obs, e);
    end
    tests++;
    if ({o_pc_plus_8_ff, o_flags_ff, o_destination_index_ff, o_mem_srcdest_index_ff,
         o_abt_ff, o_irq_ff, o_fiq_ff, o_swi_ff, o_und_ff} !==
        {32'h108, 32'hA000_0010, 6'd5, 6'd9, 5'b01010}) begin
      fails++; $display("FAIL alu_fields: pc %h flags %h dst %0d src %0d exc %b",
                        o_pc_plus_8_ff, o_flags_ff, o_destination_index_ff,
                        o_mem_srcdest_index_ff,
                        {o_abt_ff, o_irq_ff, o_fiq_ff, o_swi_ff, o_und_ff});
    end
  endtask

  task automatic test_signed_byte_load();
    res_t e;
    int   st;
    @(posedge clk); #1;
    drive_memop(32'h1003, 32'h80AABBCC, 32'h55, 4'b0100, 1'b0, 1'b1, 2, 1'b0, st);
    tests++;
    if (st !== 2) begin
      fails++; $display("FAIL sbyte_stall_cycles: got %0d expected 2", st);
    end
    @(negedge clk);
    tests++;
    e = scb.pop_front();
    if (obs !== e) begin
      fails++; $display("FAIL sbyte_result: got %h expected %h", obs, e);
    end
    tests++;
    if ({o_mem_rd_data_ff, o_mem_load_ff} !== {32'hFFFFFF80, 1'b1}) begin
      fails++; $display("FAIL sbyte_data: got %h load %b expected ffffff80 load 1",
                        o_mem_rd_data_ff, o_mem_load_ff);
    end
  endtask

  task automatic test_unaligned_word();
    res_t e;
    int   st;
    @(posedge clk); #1;
    drive_memop(32'h2001, 32'h11223344, 32'h66, 4'b0000, 1'b0, 1'b1, 0, 1'b0, st);
    tests++;
    if (st !== 0) begin
      fails++; $display("FAIL word_stall_cycles: got %0d expected 0", st);
    end
    @(negedge clk);
    tests++;
    e = scb.pop_front();
    if (obs !== e || o_mem_rd_data_ff !== 32'h44112233) begin
      fails++; $display("FAIL word_result: got %h expected %h (data 44112233)", obs, e);
    end
  endtask

  task automatic test_align_patterns();
    logic [31:0] addrs[6] = '{32'h0001, 32'h0002, 32'h0003, 32'h0000, 32'h0000, 32'h0002};
    logic [31:0] datas[6] = '{32'h12345678, 32'h80017F00, 32'h80017F00,
                              32'h0000F00D, 32'h000000FF, 32'hCAFEBABE};
    logic [3:0]  szs[6]   = '{4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0000};
    logic        wes[6]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          lates[6] = '{1, 0, 0, 3, 0, 1};
    res_t        e;
    int          st;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      drive_memop(addrs[k], datas[k], 32'h100 + k, szs[k], wes[k], 1'b1, lates[k], 1'b0, st);
      tests++;
      if (st !== lates[k]) begin
        fails++; $display("FAIL align%0d_stall_cycles: got %0d expected %0d", k, st, lates[k]);
      end
      @(negedge clk);
      tests++;
      e = scb.pop_front();
      if (obs !== e) begin
        fails++; $display("FAIL align%0d_result: got %h expected %h", k, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t        e;
    logic [31:0] addr, data, alu;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests++;
        e = scb.pop_front();
        if (obs !== e) begin
          fails++; $display("FAIL b2b%0d_result: got %h expected %h", i - 1, obs, e);
        end
      end
      if (i < 6) begin
        idle_inputs();
        alu = $urandom;
        i_dav_ff = 1; i_alu_result_ff = alu;
        if (i % 2 == 1) begin
          addr = $urandom; data = $urandom;
          i_data_wb_cyc_ff = 1; i_data_wb_stb_ff = 1; i_mem_load_ff = 1;
          i_mem_address_ff = addr; i_mem_ack = 1; i_mem_rd_data = data;
          m_rd = ref_align(data, addr[1:0], 4'b0000);
          e = {1'b1, 1'b1, 1'b0, m_rd, alu, m_fa};
        end else begin
          e = {1'b1, 1'b0, 1'b0, m_rd, alu, m_fa};
        end
        scb.push_back(e);
        #1;
        tests++;
        if (o_stall !== 1'b0) begin
          fails++; $display("FAIL b2b%0d_stall: got %b expected 0", i, o_stall);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_data_fault();
    int st;
    @(posedge clk); #1;
    drive_memop(32'h3004, 32'h99999999, 32'h77, 4'b0000, 1'b0, 1'b1, 1, 1'b1, st);
    @(negedge clk);
    tests++;
    if ({o_dav_ff, o_data_abt_ff, o_mem_load_ff, o_fault_address_ff} !==
        {1'b1, 1'b1, 1'b0, 32'h3004}) begin
      fails++; $display("FAIL fault_result: dav %b abt %b load %b addr %h expected 1 1 0 00003004",
                        o_dav_ff, o_data_abt_ff, o_mem_load_ff, o_fault_address_ff);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_dav_ff = 1; i_data_wb_cyc_ff = 1; i_data_wb_stb_ff = 1; i_mem_load_ff = 1;
      i_mem_address_ff = 32'h5000 + 4 * k; i_mem_ack = 1; i_mem_rd_data = 32'h1234;
      #1;
      tests++;
      if (o_stall !== 1'b0) begin
        fails++; $display("FAIL sleep%0d_stall: got %b expected 0", k, o_stall);
      end
      @(negedge clk);
      tests++;
      if ({o_dav_ff, o_data_abt_ff, o_mem_load_ff} !== 3'b010) begin
        fails++; $display("FAIL sleep%0d_dav: dav %b abt %b load %b expected 0 1 0",
                          k, o_dav_ff, o_data_abt_ff, o_mem_load_ff);
      end
      idle_inputs();
    end
    i_clear_from_writeback = 1;
    @(negedge clk);
    i_clear_from_writeback = 0;
    tests++;
    if ({o_dav_ff, o_data_abt_ff, o_mem_load_ff} !== 3'b000) begin
      fails++; $display("FAIL fault_clear: dav %b abt %b load %b expected 0 0 0",
                        o_dav_ff, o_data_abt_ff, o_mem_load_ff);
    end
  endtask

  task automatic test_flush_and_reset();
    res_t e;
    @(posedge clk); #1;
    i_dav_ff = 1; i_data_wb_cyc_ff = 1; i_data_wb_stb_ff = 1; i_mem_load_ff = 1;
    i_mem_address_ff = 32'h4000;
    #1;
    tests++;
    if (o_stall !== 1'b1) begin
      fails++; $display("FAIL flush_stall_idle: got %b expected 1", o_stall);
    end
    @(posedge clk); #1;
    tests++;
    if (o_stall !== 1'b1) begin
      fails++; $display("FAIL flush_stall_wait: got %b expected 1", o_stall);
    end
    i_clear_from_writeback = 1;
    #1;
    tests++;
    if (o_stall !== 1'b0) begin
      fails++; $display("FAIL flush_stall_clear: got %b expected 0", o_stall);
    end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    tests++;
    if ({o_dav_ff, o_mem_load_ff, o_stall} !== 3'b000) begin
      fails++; $display("FAIL flush_outputs: dav %b load %b stall %b expected 0 0 0",
                        o_dav_ff, o_mem_load_ff, o_stall);
    end
    i_mem_ack = 1; i_mem_rd_data = 32'hBAD0BAD0;
    @(negedge clk);
    i_mem_ack = 0;
    tests++;
    if ({o_dav_ff, o_mem_load_ff, o_mem_rd_data_ff} !== {2'b00, m_rd}) begin
      fails++; $display("FAIL stray_ack: dav %b load %b data %h expected 0 0 %h",
                        o_dav_ff, o_mem_load_ff, o_mem_rd_data_ff, m_rd);
    end
    @(posedge clk); #1;
    i_dav_ff = 1; i_data_wb_cyc_ff = 1; i_data_wb_stb_ff = 1; i_mem_load_ff = 1;
    i_mem_address_ff = 32'h4100; i_alu_result_ff = 32'h31;
    @(posedge clk); #1;
    tests++;
    if (o_stall !== 1'b1) begin
      fails++; $display("FAIL rst_stall_wait: got %b expected 1", o_stall);
    end
    i_reset_n = 0;
    #1;
    tests++;
    if ({o_stall, obs} !== '0) begin
      fails++; $display("FAIL rst_midwait: stall %b outputs %h expected all 0", o_stall, obs);
    end
    m_rd = 0; m_fa = 0;
    idle_inputs();
    @(posedge clk); #1;
    i_reset_n = 1;
    #1;
    tests++;
    if (o_stall !== 1'b0) begin
      fails++; $display("FAIL rst_release_stall: got %b expected 0", o_stall);
    end
    i_dav_ff = 1; i_alu_result_ff = 32'hABCD;
    e = {1'b1, 1'b0, 1'b0, m_rd, 32'hABCD, m_fa};
    scb.push_back(e);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    tests++;
    e = scb.pop_front();
    if (obs !== e) begin
      fails++; $display("FAIL rst_then_alu: got %h expected %h", obs, e);
    end
  endtask

  initial begin
    i_reset_n = 0;
    idle_inputs();
    test_reset();
    test_alu_passthrough();
    test_signed_byte_load();
    test_unaligned_word();
    test_align_patterns();
    test_back_to_back();
    test_data_fault();
    test_flush_and_reset();
    tests++;
    if (scb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d entries left expected 0", scb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
